audio_serial_tx: RTL and testbench



---
 rtl/audio_serial_tx.sv | 126 ++++++++++++
 tb/tb_audio_serial_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_serial_tx.sv
// Serial audio transmitter: I2S, left-justified or TDM framing with a one-deep
// holding register; an empty holding register at frame load repeats the last frame.
module audio_serial_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int CHANNELS     = 2,
    parameter int BCK_DIV      = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             fmt_lj,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
    input  logic                             sample_valid,
    output logic                             sample_ready,
    input  logic                             underrun_clr,
    output logic                             underrun,
    output logic                             frame_start,
    output logic                             i2s_bck,
    output logic                             i2s_lrck,
    output logic                             i2s_data
);
    localparam int FRAME_BITS = SLOT_WIDTH * CHANNELS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = $clog2(BCK_DIV);

    typedef logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0] frame_t;

    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    frame_t                holding;
    frame_t                active;
    logic                  hold_full;
    logic                  fmt_lj_q;

    logic                  shift_evt;
    logic                  bck_rise;
    logic                  wrap;
    logic                  load;
    logic                  accept;
    logic                  fmt_nxt;
    logic [BIT_W-1:0]      bit_nxt;
    logic [BIT_W-1:0]      pos;
    frame_t                active_nxt;
    logic [FRAME_BITS-1:0] ser_nxt;
    logic                  tail_bit;
    logic                  data_nxt;
    logic                  lrck_nxt;

    assign shift_evt    = (div_cnt == DIV_W'(BCK_DIV - 1));
    assign bck_rise     = (div_cnt == DIV_W'(BCK_DIV / 2 - 1));
    assign wrap         = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign load         = shift_evt && wrap;
    assign accept       = sample_valid && !hold_full;
    assign sample_ready = !hold_full;
    assign bit_nxt      = wrap ? '0 : bit_cnt + BIT_W'(1);
    assign fmt_nxt      = load ? fmt_lj : fmt_lj_q;

    always_comb begin
        active_nxt = active;
        if (load) begin
            if (hold_full)   active_nxt = holding;
            else if (accept) active_nxt = sample_data;
        end
    end

    // Frame laid out in transmit order: stream position ch*SLOT_WIDTH+k.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_slot
        for (genvar k = 0; k < SLOT_WIDTH; k++) begin : g_bit
            if (k < SAMPLE_WIDTH) begin : g_smp
                assign ser_nxt[ch*SLOT_WIDTH + k] = active_nxt[ch][SAMPLE_WIDTH-1-k];
            end else begin : g_pad
                assign ser_nxt[ch*SLOT_WIDTH + k] = 1'b0;
            end
        end
    end

    // I2S bit 0 is the previous frame's final bit, taken before active is overwritten.
    assign tail_bit = (SAMPLE_WIDTH == SLOT_WIDTH) ? active[CHANNELS-1][0] : 1'b0;
    assign pos      = fmt_nxt ? bit_nxt : bit_nxt - BIT_W'(1);
    assign data_nxt = (!fmt_nxt && bit_nxt == '0) ? tail_bit : ser_nxt[pos];

    if (CHANNELS == 2) begin : g_lr_stereo
        assign lrck_nxt = (bit_nxt >= BIT_W'(SLOT_WIDTH));
    end else begin : g_lr_tdm
        assign lrck_nxt = (bit_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            bit_cnt     <= BIT_W'(FRAME_BITS - 1);
            holding     <= '0;
            active      <= '0;
            hold_full   <= 1'b0;
            fmt_lj_q    <= 1'b0;
            underrun    <= 1'b0;
            frame_start <= 1'b0;
            i2s_bck     <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_data    <= 1'b0;
        end else begin
            div_cnt     <= shift_evt ? '0 : div_cnt + DIV_W'(1);
            frame_start <= load;
            if (bck_rise) i2s_bck <= 1'b1;
            if (shift_evt) begin
                i2s_bck  <= 1'b0;
                bit_cnt  <= bit_nxt;
                i2s_data <= data_nxt;
                i2s_lrck <= lrck_nxt;
            end
            if (load) begin
                active   <= active_nxt;
                fmt_lj_q <= fmt_lj;
            end
            // A bypass accept at load goes straight to active and never fills holding.
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept && !load) begin
                holding   <= sample_data;
                hold_full <= 1'b1;
            end
            if (load && !hold_full && !accept) underrun <= 1'b1;
            else if (underrun_clr)             underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_serial_tx.sv
// Directed bench for audio_serial_tx: stereo (16/16), padded stereo (16/32) and
// 8-channel TDM instances sharing one clock and reset.
module tb_audio_serial_tx;
    logic         clk;
    logic         rst_n;
    logic [2:0]   fmt, vld, clr;
    logic [2:0]   rdy, urun, fs, bck, lrck, sdo;
    logic [31:0]  sd_std, sd_pad;
    logic [127:0] sd_tdm;
    int           checks, fails;

    audio_serial_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(2), .BCK_DIV(4)) u_std (
        .clk(clk), .reset_n(rst_n), .fmt_lj(fmt[0]), .sample_data(sd_std), .sample_valid(vld[0]),
        .sample_ready(rdy[0]), .underrun_clr(clr[0]), .underrun(urun[0]), .frame_start(fs[0]),
        .i2s_bck(bck[0]), .i2s_lrck(lrck[0]), .i2s_data(sdo[0]));

    audio_serial_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CHANNELS(2), .BCK_DIV(4)) u_pad (
        .clk(clk), .reset_n(rst_n), .fmt_lj(fmt[1]), .sample_data(sd_pad), .sample_valid(vld[1]),
        .sample_ready(rdy[1]), .underrun_clr(clr[1]), .underrun(urun[1]), .frame_start(fs[1]),
        .i2s_bck(bck[1]), .i2s_lrck(lrck[1]), .i2s_data(sdo[1]));

    audio_serial_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(8), .BCK_DIV(4)) u_tdm (
        .clk(clk), .reset_n(rst_n), .fmt_lj(fmt[2]), .sample_data(sd_tdm), .sample_valid(vld[2]),
        .sample_ready(rdy[2]), .underrun_clr(clr[2]), .underrun(urun[2]), .frame_start(fs[2]),
        .i2s_bck(bck[2]), .i2s_lrck(lrck[2]), .i2s_data(sdo[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for frame_start, then records nbits of data/lrck (first bit ends up in
    // the highest recorded position) and checks the 4-clk BCK shape on every bit.
    task automatic capture(input logic [1:0] dut, input int nbits, output logic [127:0] d,
                           output logic [127:0] lr, output int bck_bad, output int fs_cnt);
        int n;
        n = 0; d = '0; lr = '0; bck_bad = 0; fs_cnt = 0;
        while (fs[dut] !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        checks++;
        if (fs[dut] !== 1'b1) begin
            fails++; $display("FAIL frame_start_wait dut%0d: no frame_start after %0d clks", dut, n);
        end
        for (int b = 0; b < nbits; b++) begin
            d  = {d[126:0], sdo[dut]};
            lr = {lr[126:0], lrck[dut]};
            for (int c = 0; c < 4; c++) begin
                if (fs[dut] === 1'b1) fs_cnt++;
                if (bck[dut] !== (c >= 2)) bck_bad++;
                @(negedge clk);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vld = '0; clr = '0; fmt = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bck !== 3'b000)  begin fails++; $display("FAIL reset_bck: got %b want 000", bck); end
        checks++; if (lrck !== 3'b000) begin fails++; $display("FAIL reset_lrck: got %b want 000", lrck); end
        checks++; if (sdo !== 3'b000)  begin fails++; $display("FAIL reset_data: got %b want 000", sdo); end
        checks++; if (urun !== 3'b000) begin fails++; $display("FAIL reset_underrun: got %b want 000", urun); end
        checks++; if (fs !== 3'b000)   begin fails++; $display("FAIL reset_frame_start: got %b want 000", fs); end
        checks++; if (rdy !== 3'b111)  begin fails++; $display("FAIL reset_ready: got %b want 111", rdy); end
    endtask

    // I2S stereo, first two frames; a second write stalls until the first frame load.
    task automatic test_i2s_stereo();
        logic [127:0] d, lr;
        int bb, fc;
        fmt[0] = 1'b0; vld[0] = 1'b1; sd_std = {16'h0F0F, 16'hA5F0}; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rdy[0] !== 1'b0) begin fails++; $display("FAIL bp_ready_drop: got %b want 0", rdy[0]); end
        sd_std = {16'hDEAD, 16'hBEEF};
        repeat (2) @(negedge clk);
        checks++; if (rdy[0] !== 1'b0) begin fails++; $display("FAIL bp_stall: got %b want 0", rdy[0]); end
        sd_std = {16'h8001, 16'h1234};
        @(negedge clk);
        checks++;
        if ({fs[0], rdy[0]} !== 2'b11) begin fails++; $display("FAIL bp_release fs,ready: got %b want 11", {fs[0], rdy[0]}); end
        fork
            capture(2'd0, 32, d, lr, bb, fc);
            begin @(negedge clk); vld[0] = 1'b0; end
        join
        checks++; if (d[31:0] !== 32'h52F80787) begin fails++; $display("FAIL i2s_f0_data: got %h want 52f80787", d[31:0]); end
        checks++; if (lr[31:0] !== 32'h0000FFFF) begin fails++; $display("FAIL i2s_f0_lrck: got %h want 0000ffff", lr[31:0]); end
        checks++; if (bb !== 0) begin fails++; $display("FAIL i2s_bck_shape: got %0d bad samples want 0", bb); end
        checks++; if (fc !== 1) begin fails++; $display("FAIL i2s_fs_count: got %0d want 1", fc); end
        checks++; if (urun[0] !== 1'b0) begin fails++; $display("FAIL i2s_f1_underrun: got %b want 0", urun[0]); end
        capture(2'd0, 32, d, lr, bb, fc);
        checks++; if (d[31:0] !== 32'h891A4000) begin fails++; $display("FAIL i2s_f1_data: got %h want 891a4000", d[31:0]); end
    endtask

    // Continues from frame 2 of the stereo run: repeat, set-wins, clear, bypass.
    task automatic test_underrun();
        logic [127:0] d, lr;
        int bb, fc;
        checks++; if (urun[0] !== 1'b1) begin fails++; $display("FAIL ur_set: got %b want 1", urun[0]); end
        fork
            capture(2'd0, 32, d, lr, bb, fc);
            begin repeat (127) @(negedge clk); clr[0] = 1'b1; @(negedge clk); clr[0] = 1'b0; end
        join
        checks++; if (d[31:0] !== 32'h891A4000) begin fails++; $display("FAIL ur_repeat_data: got %h want 891a4000", d[31:0]); end
        checks++; if (urun[0] !== 1'b1) begin fails++; $display("FAIL ur_set_wins: got %b want 1", urun[0]); end
        clr[0] = 1'b1; vld[0] = 1'b1; sd_std = {16'h0001, 16'hFFFF};
        @(negedge clk);
        checks++; if (urun[0] !== 1'b0) begin fails++; $display("FAIL ur_clear: got %b want 0", urun[0]); end
        checks++; if (rdy[0] !== 1'b0) begin fails++; $display("FAIL ur_refill_ready: got %b want 0", rdy[0]); end
        clr[0] = 1'b0; vld[0] = 1'b0;
        repeat (127) @(negedge clk);
        checks++;
        if ({fs[0], urun[0]} !== 2'b10) begin fails++; $display("FAIL ur_refill_load fs,underrun: got %b want 10", {fs[0], urun[0]}); end
        repeat (127) @(negedge clk);
        vld[0] = 1'b1; sd_std = {16'h00FF, 16'h8000};
        @(negedge clk);
        checks++;
        if ({fs[0], urun[0], rdy[0]} !== 3'b101) begin
            fails++; $display("FAIL ur_bypass fs,underrun,ready: got %b want 101", {fs[0], urun[0], rdy[0]});
        end
        vld[0] = 1'b0;
        capture(2'd0, 32, d, lr, bb, fc);
        checks++; if (d[31:0] !== 32'hC000007F) begin fails++; $display("FAIL ur_bypass_data: got %h want c000007f", d[31:0]); end
    endtask

    // fmt_lj raised just after a load only affects the following frame.
    task automatic test_lj_switch();
        logic [127:0] d, lr;
        int bb, fc;
        fmt[0] = 1'b1; vld[0] = 1'b1; sd_std = {16'h5A3C, 16'hC3A5};
        fork
            capture(2'd0, 32, d, lr, bb, fc);
            begin @(negedge clk); vld[0] = 1'b0; end
        join
        checks++; if (d[31:0] !== 32'hC000007F) begin fails++; $display("FAIL lj_midframe_data: got %h want c000007f", d[31:0]); end
        capture(2'd0, 32, d, lr, bb, fc);
        checks++; if (d[31:0] !== 32'hC3A55A3C) begin fails++; $display("FAIL lj_data: got %h want c3a55a3c", d[31:0]); end
        checks++; if (lr[31:0] !== 32'h0000FFFF) begin fails++; $display("FAIL lj_lrck: got %h want 0000ffff", lr[31:0]); end
    endtask

    task automatic test_padding();
        logic [127:0] d, lr;
        int bb, fc;
        do_reset();
        fmt[1] = 1'b1; vld[1] = 1'b1; sd_pad = {16'h0F0F, 16'hA5F0}; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        fork
            capture(2'd1, 64, d, lr, bb, fc);
            begin @(negedge clk); vld[1] = 1'b0; fmt[1] = 1'b0; end
        join
        checks++;
        if (d[63:0] !== {16'hA5F0, 16'h0000, 16'h0F0F, 16'h0000}) begin
            fails++; $display("FAIL pad_lj_data: got %h want a5f000000f0f0000", d[63:0]);
        end
        checks++;
        if (lr[63:0] !== 64'h0000_0000_FFFF_FFFF) begin fails++; $display("FAIL pad_lrck: got %h want 00000000ffffffff", lr[63:0]); end
        checks++; if (bb !== 0) begin fails++; $display("FAIL pad_bck_shape: got %0d bad samples want 0", bb); end
        capture(2'd1, 64, d, lr, bb, fc);
        checks++;
        if (d[63:0] !== {1'b0, 16'hA5F0, 16'h0000, 16'h0F0F, 15'h0000}) begin
            fails++; $display("FAIL pad_i2s_data: got %h want 52f8000007878000", d[63:0]);
        end
    endtask

    task automatic test_tdm();
        logic [127:0] d, lr, lj_exp, i2s_exp;
        int bb, fc;
        lj_exp  = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
        i2s_exp = {1'b1, lj_exp[127:1]};
        do_reset();
        fmt[2] = 1'b1; vld[2] = 1'b1; sd_tdm = 128'h7777_6666_5555_4444_3333_2222_1111_0000; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        fork
            capture(2'd2, 128, d, lr, bb, fc);
            begin @(negedge clk); vld[2] = 1'b0; fmt[2] = 1'b0; end
        join
        checks++; if (d !== lj_exp) begin fails++; $display("FAIL tdm_lj_data: got %h want %h", d, lj_exp); end
        checks++;
        if (lr !== {1'b1, 127'd0}) begin fails++; $display("FAIL tdm_sync: got %h want 8000..0", lr); end
        checks++; if (fc !== 1) begin fails++; $display("FAIL tdm_fs_count: got %0d want 1", fc); end
        checks++; if (bb !== 0) begin fails++; $display("FAIL tdm_bck_shape: got %0d bad samples want 0", bb); end
        capture(2'd2, 128, d, lr, bb, fc);
        checks++; if (d !== i2s_exp) begin fails++; $display("FAIL tdm_i2s_data: got %h want %h", d, i2s_exp); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        fmt[0] = 1'b1; vld[0] = 1'b1; sd_std = {16'hFFFF, 16'hFFFF}; rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vld[0] = 1'b0;
        repeat (81) @(negedge clk);
        checks++;
        if ({bck[0], lrck[0], sdo[0], rdy[0]} !== 4'b1110) begin
            fails++; $display("FAIL mid_precond bck,lrck,data,ready: got %b want 1110", {bck[0], lrck[0], sdo[0], rdy[0]});
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bck[0], lrck[0], sdo[0], fs[0], urun[0]} !== 5'b00000) begin
            fails++; $display("FAIL mid_reset_outputs: got %b want 00000", {bck[0], lrck[0], sdo[0], fs[0], urun[0]});
        end
        checks++; if (rdy[0] !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %b want 1", rdy[0]); end
        rst_n = 1'b1;
        n = 0;
        while (fs[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n !== 4) begin fails++; $display("FAIL mid_first_frame: got %0d clks want 4", n); end
        checks++;
        if ({urun[0], sdo[0], lrck[0]} !== 3'b100) begin
            fails++; $display("FAIL mid_empty_load underrun,data,lrck: got %b want 100", {urun[0], sdo[0], lrck[0]});
        end
    endtask

    initial begin
        checks = 0; fails = 0;
        rst_n = 1'b0; fmt = '0; vld = '0; clr = '0;
        sd_std = '0; sd_pad = '0; sd_tdm = '0;
        test_reset();
        test_i2s_stereo();
        test_underrun();
        test_lj_switch();
        test_padding();
        test_tdm();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
